noc2validready_handshake_adapter: RTL and testbench
===================================================

# noc2validready_handshake_adapter

Receive-side adapter that terminates the NoC credit-based link and presents its flits on a standard valid/ready stream. It is the counterpart of the valid/ready-to-NoC adapter: the NoC router output port drives this block, and the block feeds a local consumer such as an IP core or a DMA. Incoming flits are buffered in a FIFO sized to the credit count. One credit returns to the router for every flit the consumer accepts.

## Interface
Parameters:
- DATA_WIDTH, 64, flit/payload width in bits
- FIFO_DEPTH, 4, buffer entries; equals the credits the upstream router holds after reset; power of two, at least 2

Ports:
- clk_i  in  1  clock; all logic on the rising edge
- rst_i  in  1  reset, asynchronous, active-high
- noc_flit_i  in  DATA_WIDTH  flit from the NoC
- noc_valid_i  in  1  flit valid; one flit per cycle when high
- noc_credit_o  out  1  credit return; one-cycle pulse per freed entry
- m_data_o  out  DATA_WIDTH  stream payload (FIFO head)
- m_valid_o  out  1  stream valid
- m_ready_i  in  1  stream ready from the consumer
- occupancy_o  out  $clog2(FIFO_DEPTH+1)  current FIFO entry count
- err_overflow_o  out  1  sticky overflow flag (see Configuration)

## Operation
- Push: when noc_valid_i=1 and count<FIFO_DEPTH, the flit is written at the write pointer and the write pointer increments modulo FIFO_DEPTH.
- Pop: when m_valid_o and m_ready_i are both high, the read pointer increments modulo FIFO_DEPTH.
- Simultaneous push and pop with count<FIFO_DEPTH: the count is unchanged and both pointers advance.
- Overflow:
  - Condition: noc_valid_i=1 while count==FIFO_DEPTH. This is evaluated before any same-cycle pop, so a push in the same cycle as a pop from a full FIFO is also an overflow.
  - The flit is dropped; pointers and count are unaffected by the push.
  - This is an upstream protocol violation, because a credit is only returned one cycle after the pop.
- m_valid_o = (count != 0). m_data_o = mem[rd_ptr], driven combinationally from the registered storage.
- Payload is stable while m_valid_o=1 and m_ready_i=0 (AXI-stream rule). The block never drops m_valid_o without a pop.
- Credit: noc_credit_o is a register set to 1 in the cycle after each pop and 0 otherwise. Back-to-back pops produce back-to-back credit pulses.
- Credit invariant: upstream credits + occupancy + pending credit pulses = FIFO_DEPTH.
- Counter arithmetic: count is $clog2(FIFO_DEPTH+1) bits and saturates by construction. Pointers are $clog2(FIFO_DEPTH) bits and wrap naturally.

## Timing
- Reset values: count=0, pointers=0, noc_credit_o=0, m_valid_o=0, occupancy_o=0, err_overflow_o=0. m_data_o is don't-care; storage is not reset.
- Reset asserted mid-operation: the contents are discarded immediately (asynchronously) and no credits are returned for them. The upstream router must be reset together with this block to restore FIFO_DEPTH credits.
- Flit-in to m_valid_o: 1 cycle. A flit pushed at edge N is visible after edge N, with m_valid_o=1 in cycle N+1.
- Pop to credit: 1 cycle. A pop at edge N drives noc_credit_o=1 during cycle N+1.
- Sustained throughput: 1 flit/cycle in steady state with FIFO_DEPTH≥2 and m_ready_i held at 1.
- No combinational path exists from noc_valid_i to m_valid_o, or from m_ready_i to noc_credit_o.

## Configuration
- Macro: NOC2VR_OVERFLOW_CHECK_EN.
- Defined:
  - err_overflow_o sets on the first overflow event and stays set until rst_i.
  - A simulation-only assertion fires on the overflow condition.
- Undefined:
  - err_overflow_o is tied to 0 and no detection logic is generated.
  - An overflow flit is still dropped; the datapath behaviour is identical.

## Structure
- Shared package noc2validready_pkg holds:
  - the localparams CNT_W = $clog2(FIFO_DEPTH+1) and PTR_W = $clog2(FIFO_DEPTH), as functions of the parameters;
  - a typedef for the flit.
- Sub-module noc2validready_fifo holds the storage, pointers and count, with push/pop/full/empty/count ports. The top level adds the credit register, the valid/ready mapping and the overflow logic.

## Test plan
- Reset, then one flit 0xA5 with m_ready_i=1 → m_valid_o high one cycle after the push with m_data_o=0xA5, then noc_credit_o pulses exactly once in the following cycle.
- Four back-to-back flits 1..4 with m_ready_i=0 → occupancy_o reaches 4 and no credit is returned. Then m_ready_i=1 → flits pop in order 1,2,3,4 with four consecutive credit pulses, and occupancy_o returns to 0.
- Continuous push with m_ready_i=1 for 100 flits → 100 flits out in order, 1 flit/cycle, total credit pulses = 100.
- FIFO full (4 entries) plus a fifth flit 0xFF pushed in the same cycle as a pop → 0xFF never appears on the stream. With NOC2VR_OVERFLOW_CHECK_EN, err_overflow_o=1 from the next cycle until reset; without the macro it stays 0.
- Random m_ready_i back-pressure → m_data_o is stable whenever m_valid_o=1 and m_ready_i=0, and the credit invariant holds every cycle.
- rst_i asserted with 3 entries buffered → m_valid_o, occupancy_o and noc_credit_o are 0 immediately, without waiting for a clock edge, and no credit pulses occur.

Source files
------------

// File: rtl/noc2validready_pkg.sv
// rtl/noc2validready_pkg.sv - shared widths, flit type and sizing helpers
// Module parameters override the defaults; helpers derive widths from them.
package noc2validready_pkg;

  localparam int DEF_DATA_WIDTH = 64;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int CNT_W          = $clog2(DEF_FIFO_DEPTH + 1);
  localparam int PTR_W          = $clog2(DEF_FIFO_DEPTH);

  typedef logic [DEF_DATA_WIDTH-1:0] flit_t;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/noc2validready_handshake_adapter_if.sv
// rtl/noc2validready_handshake_adapter_if.sv - NoC-side and stream-side bundle
// Field names are seen from the adapter: _i fields enter it, _o fields leave it.
interface noc2validready_handshake_adapter_if #(
  parameter int DATA_WIDTH = 64,
  parameter int FIFO_DEPTH = 4
) ();

  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);

  logic [DATA_WIDTH-1:0] noc_flit_i;
  logic                  noc_valid_i;
  logic                  noc_credit_o;
  logic [DATA_WIDTH-1:0] m_data_o;
  logic                  m_valid_o;
  logic                  m_ready_i;
  logic [OCC_W-1:0]      occupancy_o;
  logic                  err_overflow_o;

  modport slave (
    input  noc_flit_i, noc_valid_i, m_ready_i,
    output noc_credit_o, m_data_o, m_valid_o, occupancy_o, err_overflow_o
  );

  modport master (
    output noc_flit_i, noc_valid_i, m_ready_i,
    input  noc_credit_o, m_data_o, m_valid_o, occupancy_o, err_overflow_o
  );

endinterface

// File: rtl/noc2validready_fifo.sv
// rtl/noc2validready_fifo.sv - flit buffer with pointers and occupancy count
// Callers must only push when not full and only pop when not empty.
module noc2validready_fifo
  import noc2validready_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             push_i,
  input  logic                             pop_i,
  input  logic [DATA_WIDTH-1:0]            wdata_i,
  output logic [DATA_WIDTH-1:0]            rdata_o,
  output logic                             full_o,
  output logic                             empty_o,
  output logic [cnt_w(FIFO_DEPTH)-1:0]     count_o
);

  localparam int PTR_BITS = ptr_w(FIFO_DEPTH);
  localparam int CNT_BITS = cnt_w(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_BITS-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_BITS-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_BITS-1:0]   count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + PTR_BITS'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_BITS'(1);
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CNT_BITS'(1);
      2'b01:   count_d = count_q - CNT_BITS'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage has no reset; only the pointers decide what is valid.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = (count_q == CNT_BITS'(FIFO_DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/noc2validready_handshake_adapter.sv
// rtl/noc2validready_handshake_adapter.sv - NoC credit link to valid/ready stream
// NOC2VR_OVERFLOW_CHECK_EN enables the sticky overflow flag and its assertion.
module noc2validready_handshake_adapter
  import noc2validready_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  noc2validready_handshake_adapter_if.slave  bus
);

  localparam int CNT_BITS = cnt_w(FIFO_DEPTH);

  logic                push;
  logic                pop;
  logic                full;
  logic                empty;
  logic [CNT_BITS-1:0] count;
  logic                credit_q, credit_d;

  // Full is checked before any same-cycle pop, so a push into a full FIFO drops.
  assign push = bus.noc_valid_i && !full;
  assign pop  = !empty && bus.m_ready_i;

  noc2validready_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (bus.noc_flit_i),
    .rdata_o (bus.m_data_o),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  assign credit_d = pop;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) credit_q <= 1'b0;
    else       credit_q <= credit_d;
  end

  assign bus.m_valid_o    = !empty;
  assign bus.occupancy_o  = count;
  assign bus.noc_credit_o = credit_q;

`ifdef NOC2VR_OVERFLOW_CHECK_EN
  logic overflow;
  logic err_q, err_d;

  assign overflow = bus.noc_valid_i && full;
  assign err_d    = err_q || overflow;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign bus.err_overflow_o = err_q;

`ifndef SYNTHESIS
  always @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!overflow) else $error("noc2validready: flit received with no credit outstanding");
    end
  end
`endif
`else
  assign bus.err_overflow_o = 1'b0;
`endif

endmodule

// File: tb/tb_noc2validready_handshake_adapter.sv
// tb/tb_noc2validready_handshake_adapter.sv - directed bench for the NoC receive adapter
module tb_noc2validready_handshake_adapter;
  import noc2validready_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  noc2validready_handshake_adapter_if #(.DATA_WIDTH(64), .FIFO_DEPTH(4)) ifc ();

  noc2validready_handshake_adapter #(.DATA_WIDTH(64), .FIFO_DEPTH(4)) u_dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (ifc.slave)
  );

  int    total = 0;
  int    bad = 0;
  int    credits = 0;
  int    pops = 0;
  int    up = 4;
  flit_t q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // One clock: expected queue updated from the inputs in force, then outputs checked.
  task automatic tick();
    logic cr;
    logic sent;
    bit   was_full;
    was_full = (q.size() >= 4);
    if (q.size() != 0 && ifc.m_ready_i) begin
      chk("pop_data", ifc.m_data_o, q[0]);
      void'(q.pop_front());
      pops++;
    end
    if (ifc.noc_valid_i && !was_full) q.push_back(ifc.noc_flit_i);
    cr   = ifc.noc_credit_o;
    sent = ifc.noc_valid_i;
    @(posedge clk);
    @(negedge clk);
    if (ifc.noc_credit_o) credits++;
    up = up - int'(sent) + int'(cr);
    chk("valid", {63'd0, ifc.m_valid_o}, {63'd0, q.size() != 0});
    chk("occ", 64'(ifc.occupancy_o), 64'(q.size()));
  endtask

  initial begin
    int    c0;
    int    p0;
    logic  exp_err;
    logic  hold;
    flit_t hold_data;

    ifc.noc_flit_i  = '0;
    ifc.noc_valid_i = 1'b0;
    ifc.m_ready_i   = 1'b0;
`ifdef NOC2VR_OVERFLOW_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif

    // Reset values
    @(negedge clk);
    @(negedge clk);
    chk("rst_valid", {63'd0, ifc.m_valid_o}, 64'd0);
    chk("rst_occ", 64'(ifc.occupancy_o), 64'd0);
    chk("rst_credit", {63'd0, ifc.noc_credit_o}, 64'd0);
    chk("rst_err", {63'd0, ifc.err_overflow_o}, 64'd0);
    rst = 1'b0;

    // Single flit 0xA5
    c0 = credits;
    ifc.m_ready_i   = 1'b1;
    ifc.noc_valid_i = 1'b1;
    ifc.noc_flit_i  = 64'hA5;
    tick();
    chk("a5_valid", {63'd0, ifc.m_valid_o}, 64'd1);
    chk("a5_data", ifc.m_data_o, 64'hA5);
    chk("a5_credit_early", {63'd0, ifc.noc_credit_o}, 64'd0);
    ifc.noc_valid_i = 1'b0;
    tick();
    chk("a5_credit", {63'd0, ifc.noc_credit_o}, 64'd1);
    tick();
    chk("a5_credit_end", {63'd0, ifc.noc_credit_o}, 64'd0);
    chk("a5_credit_count", 64'(credits - c0), 64'd1);

    // Fill to four with back-pressure, then drain
    c0 = credits;
    ifc.m_ready_i = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      ifc.noc_valid_i = 1'b1;
      ifc.noc_flit_i  = 64'(i);
      tick();
      chk("fill_no_credit", {63'd0, ifc.noc_credit_o}, 64'd0);
    end
    chk("fill_occ", 64'(ifc.occupancy_o), 64'd4);
    ifc.noc_valid_i = 1'b0;
    ifc.m_ready_i   = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("drain_head", ifc.m_data_o, 64'(i));
      tick();
      chk("drain_credit", {63'd0, ifc.noc_credit_o}, 64'd1);
    end
    tick();
    chk("drain_credit_end", {63'd0, ifc.noc_credit_o}, 64'd0);
    chk("drain_credit_count", 64'(credits - c0), 64'd4);
    chk("drain_occ", 64'(ifc.occupancy_o), 64'd0);

    // Streaming: 100 flits at one per cycle
    c0 = credits;
    p0 = pops;
    for (int i = 0; i < 100; i++) begin
      ifc.noc_valid_i = 1'b1;
      ifc.noc_flit_i  = 64'(1000 + i);
      tick();
      chk("stream_occ", 64'(ifc.occupancy_o), 64'd1);
    end
    ifc.noc_valid_i = 1'b0;
    tick();
    tick();
    chk("stream_pops", 64'(pops - p0), 64'd100);
    chk("stream_credits", 64'(credits - c0), 64'd100);

    // Overflow: fifth flit arrives with a pop from a full FIFO
    ifc.m_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ifc.noc_valid_i = 1'b1;
      ifc.noc_flit_i  = 64'(16 + i);
      tick();
    end
    ifc.noc_flit_i = 64'hFF;
    ifc.m_ready_i  = 1'b1;
    tick();
    chk("ovf_occ", 64'(ifc.occupancy_o), 64'd3);
    chk("ovf_err", {63'd0, ifc.err_overflow_o}, {63'd0, exp_err});
    ifc.noc_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("ovf_empty", 64'(ifc.occupancy_o), 64'd0);
    chk("ovf_err_sticky", {63'd0, ifc.err_overflow_o}, {63'd0, exp_err});

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    up = 4;
    chk("ovf_err_cleared", {63'd0, ifc.err_overflow_o}, 64'd0);

    // Random back-pressure with a credit-respecting sender
    for (int i = 0; i < 300; i++) begin
      ifc.m_ready_i   = 1'($urandom_range(0, 1));
      ifc.noc_valid_i = (up > 0) && ($urandom_range(0, 3) != 0);
      ifc.noc_flit_i  = {$urandom, $urandom};
      hold      = ifc.m_valid_o && !ifc.m_ready_i;
      hold_data = ifc.m_data_o;
      tick();
      if (hold) chk("stable_data", ifc.m_data_o, hold_data);
      chk("credit_inv", 64'(up + int'(ifc.occupancy_o) + int'(ifc.noc_credit_o)), 64'd4);
    end
    ifc.noc_valid_i = 1'b0;
    ifc.m_ready_i   = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    chk("rand_up_restored", 64'(up + int'(ifc.noc_credit_o)), 64'd4);

    // Asynchronous reset with three entries buffered
    ifc.m_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ifc.noc_valid_i = 1'b1;
      ifc.noc_flit_i  = 64'(48 + i);
      tick();
    end
    ifc.noc_valid_i = 1'b0;
    chk("pre_rst_occ", 64'(ifc.occupancy_o), 64'd3);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", {63'd0, ifc.m_valid_o}, 64'd0);
    chk("arst_occ", 64'(ifc.occupancy_o), 64'd0);
    chk("arst_credit", {63'd0, ifc.noc_credit_o}, 64'd0);
    ifc.m_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("arst_no_credit", {63'd0, ifc.noc_credit_o}, 64'd0);
    end
    rst = 1'b0;
    q.delete();
    @(negedge clk);
    chk("post_rst_credit", {63'd0, ifc.noc_credit_o}, 64'd0);
    chk("post_rst_valid", {63'd0, ifc.m_valid_o}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
